// File: rtl/nibble_serial_cmp_accum_pkg.sv
// Shared types for the nibble-serial wide comparator accumulator.
// The verdict is a 3-bit one-hot {gt, lt, eq}; all zero only out of reset.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] GT   = 3'b100;
  localparam logic [2:0] LT   = 3'b010;
  localparam logic [2:0] EQ   = 3'b001;
  localparam logic [2:0] NONE = 3'b000;

  localparam int NIBBLES_DEFAULT = 4;

  // gt beats lt; a beat with neither flag leaves the verdict alone
  function automatic logic [2:0] decide(
    input logic gt,
    input logic lt
  );
    logic [2:0] v;
    v = EQ;
    if (gt) begin
      v = GT;
    end else if (lt) begin
      v = LT;
    end
    return v;
  endfunction

endpackage

// File: rtl/nibble_serial_cmp_accum_if.sv
// Handshake and flag bundle between the nibble source/result sink
// and the nibble-serial comparator accumulator.
interface nibble_serial_cmp_accum_if;

  logic start;
  logic nib_valid;
  logic nib_ready;
  logic cmp_gt;
  logic cmp_lt;
  logic cmp_eq;
  logic res_valid;
  logic res_ready;
  logic res_gt;
  logic res_lt;
  logic res_eq;
  logic busy;
  logic err;

  modport master (
    output start,
    output nib_valid,
    output cmp_gt,
    output cmp_lt,
    output cmp_eq,
    output res_ready,
    input  nib_ready,
    input  res_valid,
    input  res_gt,
    input  res_lt,
    input  res_eq,
    input  busy,
    input  err
  );

  modport slave (
    input  start,
    input  nib_valid,
    input  cmp_gt,
    input  cmp_lt,
    input  cmp_eq,
    input  res_ready,
    output nib_ready,
    output res_valid,
    output res_gt,
    output res_lt,
    output res_eq,
    output busy,
    output err
  );

endinterface

// File: rtl/nibble_serial_cmp_accum_onehot_chk.sv
// Combinational checker: flags an invalid comparator flag triple
// (anything other than exactly one of gt/lt/eq set).
module cmp_flag_onehot_chk (
  input  logic [2:0] flags,
  output logic       bad
);

  always_comb begin
    bad = 1'b1;
    unique case (flags)
      3'b100,
      3'b010,
      3'b001:  bad = 1'b0;
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/nibble_serial_cmp_accum.sv
// Folds per-nibble comparator flags (MSB first) into a wide verdict.
// Define CMP_ONEHOT_CHECK_EN to build the sticky non-one-hot err flag.
module nibble_serial_cmp_accum
  import cmp_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  nibble_serial_cmp_accum_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dec_q;
  logic             dec_d;
  logic [2:0]       verd_q;
  logic [2:0]       verd_d;
  logic             beat;
  logic [2:0]       beat_v;

  assign beat   = bus.nib_valid && (state_q == ACCUM);
  assign beat_v = decide(bus.cmp_gt, bus.cmp_lt);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    verd_d  = verd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          cnt_d   = '0;
          dec_d   = 1'b0;
          verd_d  = EQ;
        end
      end
      ACCUM: begin
        if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!dec_q && (beat_v != EQ)) begin
            verd_d = beat_v;
            dec_d  = 1'b1;
          end
          if (cnt_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          if (bus.start) begin
            state_d = ACCUM;
            cnt_d   = '0;
            dec_d   = 1'b0;
            verd_d  = EQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      verd_q  <= NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      verd_q  <= verd_d;
    end
  end

  assign bus.nib_ready = (state_q == ACCUM);
  assign bus.res_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_gt    = verd_q[2];
  assign bus.res_lt    = verd_q[1];
  assign bus.res_eq    = verd_q[0];

`ifdef CMP_ONEHOT_CHECK_EN
  logic flag_bad;
  logic err_q;

  cmp_flag_onehot_chk u_chk (
    .flags ({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq}),
    .bad   (flag_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (beat && flag_bad) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  // eq only matters to the checker; the verdict treats it as "no change"
  logic unused_eq;
  assign unused_eq = bus.cmp_eq;
  assign bus.err   = 1'b0;
`endif

endmodule
